nibble_alu_sequencer: RTL and testbench
=======================================

// Module: nibble_alu_sequencer
// PURPOSE
//  Multi-cycle WIDTH-bit ALU built from one 4-bit ALU slice time-shared over nibbles, LSB first.
//  Carry is chained through a register between nibbles; set (SLT) and overflow come from the MSB nibble.
//  Sits beside the EX stage for area-reduced builds: start/ready/done handshake, results held until next op.
// PARAMETERS
//  WIDTH   32   operand/result width; must be a multiple of 4 and >= 8
//  NIBBLES WIDTH/4  localparam, not overridable: number of slice passes
// PORTS
//  clk       in   1      single clock, rising edge
//  rst_n     in   1      asynchronous active-low reset
//  start     in   1      request; accepted only on a clk edge where ready=1
//  a         in   WIDTH  operand A, sampled with accepted start
//  b         in   WIDTH  operand B, sampled with accepted start
//  op        in   3      op code, sampled with start; op[2] = binv (also initial carry-in)
//  ready     out  1      1 = IDLE, can accept start
//  done      out  1      one-cycle pulse: result/zero/overflow valid from this cycle on
//  result    out  WIDTH  registered result, held until next done
//  zero      out  1      registered (result == 0)
//  overflow  out  1      registered signed overflow (add/sub only, else 0)
// BEHAVIOUR
//  Op codes: 000 AND, 001 OR, 010 ADD, 110 SUB (a + ~b + 1), 111 SLT (signed a<b); others = unused.
//  Reset (async, rst_n=0): state IDLE, ready=1, done=0, result=0, zero=1, overflow=0,
//   carry/index/operand regs=0. Reset mid-operation aborts it; no done is produced.
//  FSM: IDLE -> RUN on start&ready; RUN stays NIBBLES cycles (index 0..NIBBLES-1) -> FIN;
//   FIN (1 cycle) -> IDLE. ready=1 only in IDLE.
//  Accept edge: latch a,b,op; carry_reg <= op[2]; index <= 0.
//  RUN cycle i: slice on a[4i+3:4i], b[4i+3:4i] (b inverted when op[2]); sum/logic nibble
//   written into accumulator bits [4i+3:4i]; carry_reg <= slice carry-out.
//  Last RUN cycle also records: ovf = cin_msb ^ cout_msb of bit WIDTH-1; sign = sum bit WIDTH-1.
//  FIN: set = sign ^ ovf. result <= (op==111) ? {WIDTH-1 zeros, set} : accumulator;
//   overflow <= ovf for 010/110, else 0; zero <= (new result == 0); done=1 this cycle only.
//  Latency: done asserts NIBBLES+1 cycles after the accepting edge; next start accepted
//   earliest the cycle after done (throughput NIBBLES+2 cycles/op).
//  start while ready=0 is ignored (not queued); start held high re-triggers from IDLE.
//  Operand/op inputs may change freely after the accept edge; only latched copies are used.
//  Unused op codes: complete full sequence, result=0, zero=1, overflow=0.
//  Carry out of MSB is discarded (no unsigned carry output); add wraps modulo 2^WIDTH.
//  result/zero/overflow change only at the FIN edge or reset; stable in IDLE and RUN.
// CONFIGURATION
//  ALU_SEQ_NOR_EN defined: op 100 = NOR (~(a|b)), per nibble like OR; overflow 0, set unused.
//  ALU_SEQ_NOR_EN undefined: op 100 is an unused code (result 0, zero 1, overflow 0).
// TESTING (WIDTH=32, NIBBLES=8)
//  ADD 0x7FFFFFFF + 0x00000001 -> result 0x80000000, overflow 1, zero 0, done 9 cycles after accept.
//  SUB 0x00000005 - 0x00000007 -> 0xFFFFFFFE, overflow 0; SUB 0x1234 - 0x1234 -> 0, zero 1.
//  SLT 0xFFFFFFFF vs 0x00000002 -> 1; SLT 0x7FFFFFFF vs 0x80000000 -> 0 (ovf-corrected), overflow 0.
//  AND 0xF0F0F0F0,0xFF00FF00 -> 0xF000F000; start pulsed during RUN ignored, one done only.
//  Drop rst_n in RUN cycle 4 -> ready=1, done never pulses, result 0, zero 1; next op correct.
//  op 100 on 0x0F0F0000,0x00FF0000: with ALU_SEQ_NOR_EN -> 0xF000FFFF; without -> 0, zero 1.

Source files
------------

// File: rtl/nibble_alu_sequencer.sv
// rtl/nibble_alu_sequencer.sv - multi-cycle ALU time-sharing one 4-bit slice over nibbles (optional macro ALU_SEQ_NOR_EN)
module nibble_alu_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow
);

   localparam int NIBBLES = WIDTH / 4;
   localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIN  = 2'd2;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_NOR = 3'b100;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [2:0]       r_op;
   logic             r_carry;
   logic [IDX_W-1:0] r_idx;
   logic [WIDTH-1:0] r_acc;
   logic             r_ovf;
   logic             r_sign;
   logic [WIDTH-1:0] r_result;
   logic             r_zero;
   logic             r_overflow;
   logic             r_done;

   logic [IDX_W+1:0] w_base;
   logic [3:0]       w_a_nib;
   logic [3:0]       w_b_nib;
   logic [3:0]       w_b_eff;
   logic [3:0]       w_low3;
   logic             w_c3;
   logic             w_cout;
   logic [3:0]       w_sum_nib;
   logic [3:0]       w_nib_out;
   logic             w_set;
   logic [WIDTH-1:0] w_new_result;
   logic             w_new_ovf;

   // 4-bit slice: operand nibble select, adder with carry into bit 3 exposed, op mux
   always_comb begin
      w_base  = {r_idx, 2'b00};
      w_a_nib = r_a[w_base +: 4];
      w_b_nib = r_b[w_base +: 4];
      w_b_eff = w_b_nib ^ {4{r_op[2]}};
      w_low3  = {1'b0, w_a_nib[2:0]} + {1'b0, w_b_eff[2:0]} + {3'b000, r_carry};
      w_c3    = w_low3[3];
      {w_cout, w_sum_nib} = {1'b0, w_a_nib} + {1'b0, w_b_eff} + {4'b0000, r_carry};
      w_nib_out = 4'h0;
      case (r_op)
         OP_AND:                 w_nib_out = w_a_nib & w_b_nib;
         OP_OR:                  w_nib_out = w_a_nib | w_b_nib;
         OP_ADD, OP_SUB, OP_SLT: w_nib_out = w_sum_nib;
`ifdef ALU_SEQ_NOR_EN
         OP_NOR:                 w_nib_out = ~(w_a_nib | w_b_nib);
`else
         OP_NOR:                 w_nib_out = 4'h0;
`endif
         default:                w_nib_out = 4'h0;
      endcase
   end

   // Final result selection applied on the FIN edge; SLT is sign corrected by overflow
   always_comb begin
      w_set        = r_sign ^ r_ovf;
      w_new_result = (r_op == OP_SLT) ? {{(WIDTH-1){1'b0}}, w_set} : r_acc;
      w_new_ovf    = ((r_op == OP_ADD) || (r_op == OP_SUB)) ? r_ovf : 1'b0;
   end

   // Sequencer: accept in IDLE, one nibble per RUN cycle, publish results in FIN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_a        <= '0;
         r_b        <= '0;
         r_op       <= 3'b000;
         r_carry    <= 1'b0;
         r_idx      <= '0;
         r_acc      <= '0;
         r_ovf      <= 1'b0;
         r_sign     <= 1'b0;
         r_result   <= '0;
         r_zero     <= 1'b1;
         r_overflow <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_op    <= op;
                  r_carry <= op[2];
                  r_idx   <= '0;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_acc[w_base +: 4] <= w_nib_out;
               r_carry            <= w_cout;
               if (r_idx == LAST_IDX) begin
                  r_ovf   <= w_c3 ^ w_cout;
                  r_sign  <= w_sum_nib[3];
                  r_state <= S_FIN;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            S_FIN: begin
               r_result   <= w_new_result;
               r_zero     <= (w_new_result == '0);
               r_overflow <= w_new_ovf;
               r_done     <= 1'b1;
               r_state    <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign ready    = (r_state == S_IDLE);
   assign done     = r_done;
   assign result   = r_result;
   assign zero     = r_zero;
   assign overflow = r_overflow;

endmodule

// File: tb/tb_nibble_alu_sequencer.sv
// tb/tb_nibble_alu_sequencer.sv - self-checking bench for nibble_alu_sequencer
module tb_nibble_alu_sequencer;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [31:0] a;
   logic [31:0] b;
   logic [2:0]  op;
   logic        ready;
   logic        done;
   logic [31:0] result;
   logic        zero;
   logic        overflow;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      logic [31:0] va;
      logic [31:0] vb;
      logic [2:0]  vop;
      logic [31:0] exp_res;
      logic        exp_zero;
      logic        exp_ovf;
   } vec_t;

   vec_t vecs[10];

   nibble_alu_sequencer #(.WIDTH(32)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .a        (a),
      .b        (b),
      .op       (op),
      .ready    (ready),
      .done     (done),
      .result   (result),
      .zero     (zero),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   // Reference model: whole-word arithmetic, no nibble stepping
   task automatic model(input logic [31:0] ma, input logic [31:0] mb, input logic [2:0] mop,
                        output logic [31:0] r, output logic z, output logic v);
      logic [31:0] s;
      r = 32'h0;
      v = 1'b0;
      case (mop)
         3'b000: r = ma & mb;
         3'b001: r = ma | mb;
         3'b010: begin
            s = ma + mb;
            r = s;
            v = (ma[31] == mb[31]) && (s[31] != ma[31]);
         end
         3'b110: begin
            s = ma - mb;
            r = s;
            v = (ma[31] != mb[31]) && (s[31] != ma[31]);
         end
         3'b111: r = ($signed(ma) < $signed(mb)) ? 32'd1 : 32'd0;
`ifdef ALU_SEQ_NOR_EN
         3'b100: r = ~(ma | mb);
`endif
         default: r = 32'h0;
      endcase
      z = (r == 32'h0);
   endtask

   // Starts one op from a negedge, scrambles inputs after accept, waits for done
   task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input logic [2:0] top,
                         output logic [31:0] gr, output logic gz, output logic gv, output int lat);
      int w;
      w = 0;
      while (!ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      a = ta; b = tb; op = top; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      a = $urandom; b = $urandom; op = 3'($urandom);
      lat = 0;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      gr = result; gz = zero; gv = overflow;
      @(negedge clk);
      check("done_single_pulse", {31'b0, done}, 32'd0);
   endtask

   logic [31:0] gr, er;
   logic        gz, gv, ez, ev;
   int          lat;
   int          ndone;
   logic [2:0]  ops[8];
   logic [31:0] specials[4];
   logic [31:0] ra, rb;
   logic [2:0]  rop;

   initial begin
      vecs[0] = '{32'h7FFFFFFF, 32'h00000001, 3'b010, 32'h80000000, 1'b0, 1'b1};
      vecs[1] = '{32'h00000005, 32'h00000007, 3'b110, 32'hFFFFFFFE, 1'b0, 1'b0};
      vecs[2] = '{32'h00001234, 32'h00001234, 3'b110, 32'h00000000, 1'b1, 1'b0};
      vecs[3] = '{32'hFFFFFFFF, 32'h00000002, 3'b111, 32'h00000001, 1'b0, 1'b0};
      vecs[4] = '{32'h7FFFFFFF, 32'h80000000, 3'b111, 32'h00000000, 1'b1, 1'b0};
      vecs[5] = '{32'hF0F0F0F0, 32'hFF00FF00, 3'b000, 32'hF000F000, 1'b0, 1'b0};
      vecs[6] = '{32'hF0F0F0F0, 32'h0F000001, 3'b001, 32'hFFF0F0F1, 1'b0, 1'b0};
`ifdef ALU_SEQ_NOR_EN
      vecs[7] = '{32'h0F0F0000, 32'h00FF0000, 3'b100, 32'hF000FFFF, 1'b0, 1'b0};
`else
      vecs[7] = '{32'h0F0F0000, 32'h00FF0000, 3'b100, 32'h00000000, 1'b1, 1'b0};
`endif
      vecs[8] = '{32'h12345678, 32'h11111111, 3'b011, 32'h00000000, 1'b1, 1'b0};
      vecs[9] = '{32'h80000000, 32'h00000001, 3'b110, 32'h7FFFFFFF, 1'b0, 1'b1};
      ops      = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b100, 3'b011, 3'b101};
      specials = '{32'h0, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};

      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; op = '0;
      repeat (2) @(negedge clk);
      check("reset_ready",    {31'b0, ready},    32'd1);
      check("reset_done",     {31'b0, done},     32'd0);
      check("reset_result",   result,            32'd0);
      check("reset_zero",     {31'b0, zero},     32'd1);
      check("reset_overflow", {31'b0, overflow}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed vectors
      for (int i = 0; i < 10; i++) begin
         run_op(vecs[i].va, vecs[i].vb, vecs[i].vop, gr, gz, gv, lat);
         check($sformatf("vec%0d_result", i), gr, vecs[i].exp_res);
         check($sformatf("vec%0d_zero", i), {31'b0, gz}, {31'b0, vecs[i].exp_zero});
         check($sformatf("vec%0d_ovf", i), {31'b0, gv}, {31'b0, vecs[i].exp_ovf});
         check($sformatf("vec%0d_latency", i), lat, 32'd9);
      end

      // Start pulsed during RUN is ignored: exactly one done
      a = 32'h00000010; b = 32'h00000020; op = 3'b010; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("ready_low_in_run", {31'b0, ready}, 32'd0);
      start = 1'b1; a = 32'hDEAD0000; op = 3'b001;
      @(negedge clk);
      start = 1'b0;
      ndone = 0;
      for (int k = 0; k < 25; k++) begin
         if (done) ndone++;
         @(negedge clk);
      end
      check("run_start_one_done", ndone, 32'd1);
      check("run_start_result", result, 32'h00000030);

      // Reset during RUN cycle 4 aborts the op
      a = 32'h00000003; b = 32'h00000004; op = 3'b010; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_ready",  {31'b0, ready}, 32'd1);
      check("abort_result", result,         32'd0);
      check("abort_zero",   {31'b0, zero},  32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      for (int k = 0; k < 15; k++) begin
         if (done) ndone++;
         @(negedge clk);
      end
      check("abort_no_done", ndone, 32'd0);
      run_op(32'h0000FFFF, 32'h00000001, 3'b010, gr, gz, gv, lat);
      check("after_abort_result", gr, 32'h00010000);
      check("after_abort_latency", lat, 32'd9);

      // Randomized against the model
      for (int i = 0; i < 40; i++) begin
         ra  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
         rb  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
         rop = ops[$urandom_range(0, 7)];
         model(ra, rb, rop, er, ez, ev);
         run_op(ra, rb, rop, gr, gz, gv, lat);
         check($sformatf("rnd%0d_op%0b_result", i, rop), gr, er);
         check($sformatf("rnd%0d_zero", i), {31'b0, gz}, {31'b0, ez});
         check($sformatf("rnd%0d_ovf", i), {31'b0, gv}, {31'b0, ev});
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
